// File: rtl/bomb_placer_pkg.sv
// Shared definitions for the bomb placer: map geometry, state encodings,
// and the map index / bounds helpers used by both lanes and the top.
package bomb_placer_pkg;

  localparam int GRID             = 10;
  localparam int CELLS            = GRID * GRID;
  localparam int IDX_W            = 7;
  localparam int COOLDOWN_DEFAULT = 4;
  localparam int CD_W             = 3;

  typedef enum logic [1:0] {
    RUNNING = 2'd0,
    B_WINS  = 2'd1,
    A_WINS  = 2'd2,
    DRAW    = 2'd3
  } gameState_e;

  typedef enum logic [1:0] {
    BOMB_NONE    = 2'b00,
    BOMB_COUNT1  = 2'b01,
    BOMB_COUNT2  = 2'b10,
    BOMB_EXPLODE = 2'b11
  } bombState_e;

  typedef enum logic {
    LANE_IDLE    = 1'b0,
    LANE_PENDING = 1'b1
  } laneState_e;

  // Row-major map index; only meaningful for in-play coordinates.
  function automatic logic [IDX_W-1:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
    return IDX_W'(GRID) * {3'b000, x} + {3'b000, y};
  endfunction

  // Playable coordinates exclude the border walls.
  function automatic logic in_play(input logic [3:0] v);
    return (v != 4'd0) && (v <= 4'(GRID - 2));
  endfunction

endpackage

// File: rtl/bomb_placer_if.sv
// Issued-bomb bus from the placer to the map updater, plus cooldown display.
interface bomb_placer_if;
  import bomb_placer_pkg::*;

  logic [3:0]      bombA_x;
  logic [3:0]      bombA_y;
  logic            bombA_v;
  logic [3:0]      bombB_x;
  logic [3:0]      bombB_y;
  logic            bombB_v;
  logic [CD_W-1:0] cooldownA;
  logic [CD_W-1:0] cooldownB;

  modport master (
    output bombA_x, bombA_y, bombA_v,
    output bombB_x, bombB_y, bombB_v,
    output cooldownA, cooldownB
  );

  modport slave (
    input bombA_x, bombA_y, bombA_v,
    input bombB_x, bombB_y, bombB_v,
    input cooldownA, cooldownB
  );

endinterface

// File: rtl/bomb_placer_lane.sv
// One player's lane: button edge detect, pending request latch, cooldown
// counter, legality check and the tick-held bomb output registers.
module bomb_placer_lane
  import bomb_placer_pkg::*;
#(
  parameter int COOLDOWN_TICKS = COOLDOWN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bombTick,
  input  logic            btn,
  input  logic [3:0]      posX,
  input  logic [3:0]      posY,
  input  logic [1:0]      health,
  input  logic            gameRunning,
  input  logic            cellFree,
  input  logic            suppress,
  output logic [3:0]      reqX,
  output logic [3:0]      reqY,
  output logic            legal,
  output logic            bombV,
  output logic [3:0]      bombX,
  output logic [3:0]      bombY,
  output logic [CD_W-1:0] cooldown
);

  laneState_e      stateReg, stateNext;
  logic            btnPrevReg;
  logic [3:0]      reqXReg, reqYReg, reqXNext, reqYNext;
  logic            bombVReg, bombVNext;
  logic [3:0]      bombXReg, bombYReg, bombXNext, bombYNext;
  logic [CD_W-1:0] cdReg, cdNext;
  logic            alive, rise, issue;

  assign alive = (health != 2'd0);
  assign rise  = btn & ~btnPrevReg;
  assign legal = (stateReg == LANE_PENDING) && in_play(reqXReg) && in_play(reqYReg)
                 && cellFree && alive && gameRunning;
  assign issue = legal & ~suppress;

  // State registers; reset also clears the edge detector so a held button
  // coming out of reset counts as a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg   <= LANE_IDLE;
      btnPrevReg <= 1'b0;
      reqXReg    <= '0;
      reqYReg    <= '0;
      bombVReg   <= 1'b0;
      bombXReg   <= '0;
      bombYReg   <= '0;
      cdReg      <= '0;
    end else begin
      stateReg   <= stateNext;
      btnPrevReg <= btn;
      reqXReg    <= reqXNext;
      reqYReg    <= reqYNext;
      bombVReg   <= bombVNext;
      bombXReg   <= bombXNext;
      bombYReg   <= bombYNext;
      cdReg      <= cdNext;
    end
  end

  // Tick evaluation first (using the old pending state), then press capture
  // against the post-tick cooldown so a press during our own issue is lost.
  always_comb begin
    stateNext = stateReg;
    reqXNext  = reqXReg;
    reqYNext  = reqYReg;
    bombVNext = bombVReg;
    bombXNext = bombXReg;
    bombYNext = bombYReg;
    cdNext    = cdReg;
    if (bombTick) begin
      stateNext = LANE_IDLE;
      if (issue) begin
        bombVNext = 1'b1;
        bombXNext = reqXReg;
        bombYNext = reqYReg;
        cdNext    = CD_W'(COOLDOWN_TICKS);
      end else begin
        bombVNext = 1'b0;
        if (cdReg != '0) cdNext = cdReg - 1'b1;
      end
    end
    if (rise && (stateNext == LANE_IDLE) && (cdNext == '0) && alive) begin
      stateNext = LANE_PENDING;
      reqXNext  = posX;
      reqYNext  = posY;
    end
  end

  assign reqX     = reqXReg;
  assign reqY     = reqYReg;
  assign bombV    = bombVReg;
  assign bombX    = bombXReg;
  assign bombY    = bombYReg;
  assign cooldown = cdReg;

endmodule

// File: rtl/bomb_placer.sv
// Bomb placer top: two player lanes, the bomb map lookup for each pending
// request, and A-over-B arbitration when both target the same cell.
module bomb_placer
  import bomb_placer_pkg::*;
#(
  parameter int COOLDOWN_TICKS = COOLDOWN_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bombTick,
  input  logic             btnA,
  input  logic             btnB,
  input  logic [3:0]       playerAx,
  input  logic [3:0]       playerAy,
  input  logic [3:0]       playerBx,
  input  logic [3:0]       playerBy,
  input  logic [1:0]       healthA,
  input  logic [1:0]       healthB,
  input  logic [1:0]       game_state,
  input  logic [CELLS-1:0] i_curBombMap_0,
  input  logic [CELLS-1:0] i_curBombMap_1,
  bomb_placer_if.master    bus
);

  logic [3:0] reqAx, reqAy, reqBx, reqBy;
  logic       legalA, legalB;
  logic       cellFreeA, cellFreeB;
  logic       suppressB;
  logic       gameRunning;

  assign gameRunning = (game_state == RUNNING);

  // The bounds check gates the index so wall/outside coordinates never
  // address the map vectors.
  function automatic logic cellFreeAt(input logic [3:0] x, input logic [3:0] y,
                                      input logic [CELLS-1:0] m0,
                                      input logic [CELLS-1:0] m1);
    logic [IDX_W-1:0] idx;
    if (!(in_play(x) && in_play(y))) return 1'b0;
    idx = cell_idx(x, y);
    return !(m0[idx] | m1[idx]);
  endfunction

  // Map lookup for both pending requests and same-cell arbitration.
  always_comb begin
    cellFreeA = cellFreeAt(reqAx, reqAy, i_curBombMap_0, i_curBombMap_1);
    cellFreeB = cellFreeAt(reqBx, reqBy, i_curBombMap_0, i_curBombMap_1);
    suppressB = legalA && legalB && (reqAx == reqBx) && (reqAy == reqBy);
  end

  bomb_placer_lane #(.COOLDOWN_TICKS(COOLDOWN_TICKS)) laneA (
    .clk(clk), .rst(rst), .bombTick(bombTick), .btn(btnA),
    .posX(playerAx), .posY(playerAy), .health(healthA),
    .gameRunning(gameRunning), .cellFree(cellFreeA), .suppress(1'b0),
    .reqX(reqAx), .reqY(reqAy), .legal(legalA),
    .bombV(bus.bombA_v), .bombX(bus.bombA_x), .bombY(bus.bombA_y),
    .cooldown(bus.cooldownA)
  );

  bomb_placer_lane #(.COOLDOWN_TICKS(COOLDOWN_TICKS)) laneB (
    .clk(clk), .rst(rst), .bombTick(bombTick), .btn(btnB),
    .posX(playerBx), .posY(playerBy), .health(healthB),
    .gameRunning(gameRunning), .cellFree(cellFreeB), .suppress(suppressB),
    .reqX(reqBx), .reqY(reqBy), .legal(legalB),
    .bombV(bus.bombB_v), .bombX(bus.bombB_x), .bombY(bus.bombB_y),
    .cooldown(bus.cooldownB)
  );

endmodule

// File: doc/bomb_placer.md
Name: bomb_placer

Overview:
- Upstream stage of the bomb map updater. Turns each player's drop button into a one-tick bomb request: bombA_x/y/v and bombB_x/y/v.
- Latches the press and the player position, then applies the placement rules: in-bounds, empty cell, cooldown, alive, game running.
- Presents each legal request for exactly one bomb-tick period, so the map updater samples it once.
- Runs on the fast system clock; the 1 Hz bomb tick arrives as a one-cycle strobe.

Parameters:
- COOLDOWN_TICKS, 4, bomb ticks after an issued bomb before that player may request again.
- GRID, 10, map side length; cell index = GRID*x + y; playable range is 1..GRID-2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- bombTick  in  1  one-clk-cycle strobe, aligned to the bomb clock edge
- btnA, btnB  in  1  drop buttons, debounced level, active-high
- playerAx, playerAy, playerBx, playerBy  in  4  player coordinates
- healthA, healthB  in  2  current health
- game_state  in  2  0 = running, nonzero = over
- i_curBombMap_0, i_curBombMap_1  in  100  current bomb map bit-planes
- bombA_x, bombA_y, bombB_x, bombB_y  out  4  issued bomb coordinates
- bombA_v, bombB_v  out  1  issued-bomb valid
- cooldownA, cooldownB  out  3  remaining cooldown ticks, for display

Behaviour:
- Reset (sync, rst=1 at a clk edge): all outputs 0; pending flags 0; edge-detect registers 0. Reset overrides bombTick in the same cycle.
- Press capture, per player P:
  - Rising edge of btnP (registered previous level) with pendP=0, cooldownP=0 and healthP!=0 -> pendP<=1; latch reqPx/reqPy <= playerPx/playerPy from that cycle.
  - Press while pendP=1 is ignored; the first coordinates are kept.
  - Press during cooldown is discarded and not queued.
  - A held button produces one request only.
- Issue, evaluated only in a cycle with bombTick=1, per player P:
  - legalP = pendP, AND 1<=reqPx<=8, AND 1<=reqPy<=8, AND map cell (10*reqPx+reqPy) has both planes 0, AND healthP!=0, AND game_state==0.
  - legalP -> bombP_v<=1, bombP_x/y<=reqPx/y, cooldownP<=COOLDOWN_TICKS.
  - Otherwise -> bombP_v<=0, and cooldownP decrements if nonzero (saturates at 0).
  - pendP<=0 on every tick, so an illegal request is dropped, not retried.
- Hold: bombP_v/x/y change only on bombTick cycles. They stay stable for the whole tick period, so the map updater's next bomb-clock edge sees each bomb exactly once.
- Collision: both legal with equal coordinates on the same tick -> A issues, B is dropped (bombB_v<=0, B cooldown not loaded).
- Same-cycle press and tick:
  - The tick evaluates the old pend state.
  - The new press is captured only if the resulting cooldown is 0 after this tick's update. A press coincident with A's own issue is therefore discarded.
- Latency:
  - Press to valid is 1 to (tick period + 1) clk cycles.
  - Valid lasts exactly one tick period.
  - Minimum spacing between two bombs from one player is COOLDOWN_TICKS+1 ticks.
- Game over (game_state!=0): no issues; pending requests cleared at each tick; cooldowns keep decrementing.
- Arithmetic:
  - Index math is 7-bit: 10*x + y.
  - Out-of-range coordinates never index the map; the bounds check gates the index.
  - The cooldown width must hold COOLDOWN_TICKS (3 bits for the default).

Decomposition:
- Shared package holds:
  - GRID
  - map index function cell_idx(x,y)
  - game_state encodings (RUNNING=0, B_WINS=1, A_WINS=2, DRAW=3)
  - bomb state encodings: 00 none, 01/10 counting, 11 exploding
- One sub-module is natural: placer_lane, one player's edge detect, pend latch, cooldown counter and legality check. Instantiate it twice; the top level does the A-over-B collision arbitration and the map lookup.

Test Plan:
- Reset mid-pend: press A at (3,4), assert rst before the tick -> after the tick bombA_v=0, cooldownA=0.
- Basic issue: player A at (3,4), press btnA, then bombTick -> bombA_v=1, x=3, y=4 for one full tick period; cooldownA=4, then 3,2,1,0 on later ticks; a press at cooldownA=2 yields no bomb.
- Occupied and out-of-bounds: map bit 34 set in plane 0 with A at (3,4) -> bombA_v stays 0, pend cleared. A at (0,5) or (9,5) -> no bomb.
- Collision: A and B both at (5,5), both press before the same tick -> bombA_v=1, bombB_v=0, cooldownB=0.
- Held button: btnA held high across 6 ticks -> exactly one bombA_v pulse.
- Game over and dead player: game_state=2 with a press -> no bomb. healthB=0 with btnB pressed -> bombB_v never set.
